sdpram_asym_sc: RTL and testbench
=================================

Name: sdpram_asym_sc

Overview:
- Single-clock simple dual-port RAM with asymmetric port widths: wide write port A, narrow read port B.
- Per-lane write enables, correctly scaled addressing and a selectable read/write collision mode.
- Configurable read latency (1 or 2) with a valid strobe; optional post-reset memory-clear sequencer.
- Used as the narrow-drain staging buffer behind wide datapaths (e.g. 64-bit producer, 32-bit consumer).

Parameters:
- ADDR_WIDTH, 5, read-side address width in narrow words; depth = 2^ADDR_WIDTH narrow words.
- DATA_WIDTH_R, 32, read word width.
- DATA_WIDTH_W, 64, write word width; must equal DATA_WIDTH_R * RATIO, RATIO a power of 2 (1..8).
- READ_LATENCY, 1, 1 = registered memory output; 2 = additional output register.
- WRITE_MODE, "READ_FIRST", "READ_FIRST" | "WRITE_FIRST" | "NO_CHANGE"; governs same-cycle collisions.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = array contents are untouched by reset.
- Derived localparams: RATIO = DATA_WIDTH_W/DATA_WIDTH_R, LR = log2(RATIO), ADDR_WIDTH_W = ADDR_WIDTH-LR.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  write enable.
- wea  input  RATIO  per-lane write enable; lane k = dina[(k+1)*DATA_WIDTH_R-1 : k*DATA_WIDTH_R].
- addra  input  ADDR_WIDTH_W  wide-word write address.
- dina  input  DATA_WIDTH_W  write data.
- enb  input  1  read enable.
- addrb  input  ADDR_WIDTH  narrow-word read address.
- doutb  output  DATA_WIDTH_R  read data.
- doutb_valid  output  1  doutb carries the result of an accepted read.
- init_busy  output  1  clear sequence in progress; ports A/B ignored.

Behaviour:
- Mapping: lane k of wide word W lives at narrow address W*RATIO+k. Lane 0 is the LSB lane.
- Write: on an accepted write (ena=1, init_busy=0), every lane with wea[k]=1 is written. Other lanes are unchanged.
- Read accept: enb=1 and init_busy=0.
  - READ_LATENCY=1: doutb/doutb_valid update on the next edge.
  - READ_LATENCY=2: one edge later.
  - doutb_valid is a pure pipeline of accept. doutb holds its last value whenever no new result arrives.
- Collision: a write and a read are accepted in the same cycle, addra == addrb[ADDR_WIDTH-1:LR] and wea[addrb[LR-1:0]] = 1.
  - READ_FIRST: returns the old memory contents.
  - WRITE_FIRST: returns the new lane of dina.
  - NO_CHANGE: the write proceeds; the read is dropped. Stage-1 doutb holds and the corresponding valid is 0.
  - A write to the same wide word that does not touch the read lane is not a collision. The read returns memory contents.
- Reset (rst=1 at an edge):
  - doutb=0, doutb_valid=0, and every pipeline register is zeroed.
  - Clear counter = 0.
  - State -> CLEAR if CLEAR_ON_RESET=1, else READY.
  - init_busy is combinational from state: 1 in CLEAR.
- FSM:
  - CLEAR: each cycle writes zero to wide word cnt (all lanes) and cnt increments. When cnt = 2^ADDR_WIDTH_W-1 is written, go to READY. This takes exactly 2^ADDR_WIDTH_W cycles; init_busy drops on the following edge.
  - READY: normal operation; no transition except via rst.
- Reset mid-CLEAR or mid-read: the sequence restarts from cnt=0 and in-flight reads are discarded (no valid emitted).
- Requests while init_busy=1 are ignored: no write, no valid, no stall indication. The requester must wait.
- Address wrap: addra/addrb cover the full depth exactly. No out-of-range case exists.
- Array contents are not reset when CLEAR_ON_RESET=0.

Test Plan:
- Reset with CLEAR_ON_RESET=1, defaults -> init_busy=1 for exactly 16 cycles then 0. Reads of addrb 0..31 return 0 with doutb_valid 1 cycle after each enb.
- Write addra=3, wea=2'b11, dina=64'hAAAA_BBBB_1111_2222 -> read addrb=6 gives 32'h1111_2222; addrb=7 gives 32'hAAAA_BBBB.
- Partial write addra=3, wea=2'b10, dina=64'hDEAD_BEEF_0000_0000 over the previous data -> addrb=6 still 32'h1111_2222, addrb=7 = 32'hDEAD_BEEF.
- Collision at addrb=7 with dina upper lane 32'h5555_5555 (old 32'hDEAD_BEEF):
  - READ_FIRST -> DEAD_BEEF.
  - WRITE_FIRST -> 5555_5555.
  - NO_CHANGE -> doutb_valid=0 and doutb unchanged.
  - In all modes a later read of addrb=7 gives 5555_5555.
- READ_LATENCY=2: back-to-back enb at addrb 6,7,6 -> valid at cycles +2,+3,+4 with matching data. Deassert enb -> valid 0 and doutb holds.
- Assert rst for 1 cycle at cycle 5 of CLEAR and during an in-flight read -> no valid emitted, init_busy high for a full 16 more cycles, and ena writes during that window are not stored.

Source files
------------

// File: rtl/sdpram_asym_sc.sv
// sdpram_asym_sc: single-clock simple dual-port RAM with a wide write port A
// and a narrow read port B. Lane k of wide word W is narrow word W*RATIO+k.
// Collisions follow WRITE_MODE. Read latency is 1 or 2 cycles with a valid
// strobe. An optional sequencer zeroes the array after reset.
module sdpram_asym_sc #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH_R   = 32,
  parameter int DATA_WIDTH_W   = 64,
  parameter int READ_LATENCY   = 1,
  parameter     WRITE_MODE     = "READ_FIRST",
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         ena,
  input  logic [DATA_WIDTH_W/DATA_WIDTH_R-1:0]                         wea,
  input  logic [ADDR_WIDTH-$clog2(DATA_WIDTH_W/DATA_WIDTH_R)-1:0]      addra,
  input  logic [DATA_WIDTH_W-1:0]                                      dina,
  input  logic                                                         enb,
  input  logic [ADDR_WIDTH-1:0]                                        addrb,
  output logic [DATA_WIDTH_R-1:0]                                      doutb,
  output logic                                                         doutb_valid,
  output logic                                                         init_busy
);

  localparam int RATIO        = DATA_WIDTH_W / DATA_WIDTH_R;
  localparam int LR           = $clog2(RATIO);
  localparam int LRW          = (LR > 0) ? LR : 1;
  localparam int ADDR_WIDTH_W = ADDR_WIDTH - LR;
  localparam int DEPTH        = 2 ** ADDR_WIDTH;
  localparam bit MODE_WF      = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_NC      = (WRITE_MODE == "NO_CHANGE");

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [ADDR_WIDTH_W-1:0]   clr_cnt;
  logic                      clr_we;

  logic [DATA_WIDTH_R-1:0]   mem [DEPTH];

  logic                      wr_acc;
  logic                      rd_acc;
  logic [ADDR_WIDTH_W-1:0]   rd_word;
  logic [LRW-1:0]            rd_lane;
  logic                      lane_hit;
  logic [DATA_WIDTH_R-1:0]   wr_lane_data;
  logic                      collision;
  logic                      drop_read;

  logic [DATA_WIDTH_R-1:0]   dout1;
  logic                      valid1;

  assign init_busy = (state_q == S_CLEAR);

  // Ports are ignored while clearing and on the reset edge itself
  assign wr_acc  = ena & ~init_busy & ~rst;
  assign rd_acc  = enb & ~init_busy & ~rst;
  assign rd_word = addrb[ADDR_WIDTH-1:LR];
  assign rd_lane = LRW'(addrb & ADDR_WIDTH'(RATIO - 1));

  // Clear sequencer next-state: walk every wide word once, then go ready
  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == {ADDR_WIDTH_W{1'b1}}) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_READY;
      end
    endcase
  end

  // State register and clear counter; reset restarts the sweep from word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Pick out the write lane that lands on the read address, and its enable
  always_comb begin
    lane_hit     = 1'b0;
    wr_lane_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (rd_lane == LRW'(k)) begin
        lane_hit     = wea[k];
        wr_lane_data = dina[k*DATA_WIDTH_R +: DATA_WIDTH_R];
      end
    end
  end

  assign collision = wr_acc & rd_acc & (addra == rd_word) & lane_hit;
  assign drop_read = collision & MODE_NC;

  // Array write: the clear sweep zeroes whole wide words, otherwise per-lane writes
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      for (int k = 0; k < RATIO; k++) begin
        mem[ADDR_WIDTH'((int'(clr_cnt) << LR) + k)] <= '0;
      end
    end else if (wr_acc) begin
      for (int k = 0; k < RATIO; k++) begin
        if (wea[k]) begin
          mem[ADDR_WIDTH'((int'(addra) << LR) + k)] <= dina[k*DATA_WIDTH_R +: DATA_WIDTH_R];
        end
      end
    end
  end

  // First read stage: registered memory output, holds when no result arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      dout1  <= '0;
      valid1 <= 1'b0;
    end else begin
      valid1 <= rd_acc & ~drop_read;
      if (rd_acc && !drop_read) begin
        dout1 <= (collision && MODE_WF) ? wr_lane_data : mem[addrb];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH_R-1:0] dout2;
      logic                    valid2;

      // Optional output register, advances only on a valid first-stage result
      always_ff @(posedge clk) begin
        if (rst) begin
          dout2  <= '0;
          valid2 <= 1'b0;
        end else begin
          valid2 <= valid1;
          if (valid1) begin
            dout2 <= dout1;
          end
        end
      end

      assign doutb       = dout2;
      assign doutb_valid = valid2;
    end else begin : g_lat1
      assign doutb       = dout1;
      assign doutb_valid = valid1;
    end
  endgenerate

endmodule

// File: tb/tb_sdpram_asym_sc.sv
// tb_sdpram_asym_sc: four instances share one stimulus stream: latency 1 in
// READ_FIRST, WRITE_FIRST and NO_CHANGE, plus latency 2 in READ_FIRST.
module tb_sdpram_asym_sc;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [1:0]  wea;
  logic [3:0]  addra;
  logic [63:0] dina;
  logic        enb;
  logic [4:0]  addrb;

  logic [31:0] dout_rf, dout_wf, dout_nc, dout_l2;
  logic        val_rf, val_wf, val_nc, val_l2;
  logic        busy_rf, busy_wf, busy_nc, busy_l2;

  int checks;
  int failures;

  sdpram_asym_sc #(.READ_LATENCY(1), .WRITE_MODE("READ_FIRST")) dut_rf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout_rf), .doutb_valid(val_rf), .init_busy(busy_rf));

  sdpram_asym_sc #(.READ_LATENCY(1), .WRITE_MODE("WRITE_FIRST")) dut_wf (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout_wf), .doutb_valid(val_wf), .init_busy(busy_wf));

  sdpram_asym_sc #(.READ_LATENCY(1), .WRITE_MODE("NO_CHANGE")) dut_nc (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout_nc), .doutb_valid(val_nc), .init_busy(busy_nc));

  sdpram_asym_sc #(.READ_LATENCY(2), .WRITE_MODE("READ_FIRST")) dut_l2 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout_l2), .doutb_valid(val_l2), .init_busy(busy_l2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] w, input logic [63:0] d);
    addra = a; wea = w; dina = d; ena = 1'b1;
    tick();
    ena = 1'b0; wea = 2'b00;
  endtask

  // Single read; returns latency-1 results after one edge and latency-2 after two
  task automatic do_read(input logic [4:0] a, output logic [2:0] v1,
                         output logic [31:0] drf, output logic [31:0] dwf,
                         output logic [31:0] dnc, output logic v2, output logic [31:0] d2);
    addrb = a; enb = 1'b1;
    tick();
    v1 = {val_rf, val_wf, val_nc}; drf = dout_rf; dwf = dout_wf; dnc = dout_nc;
    enb = 1'b0;
    tick();
    v2 = val_l2; d2 = dout_l2;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy_rf, busy_wf, busy_nc, busy_l2} !== 4'hF) begin
      failures++; $display("[TB] FAIL reset_busy got=%b exp=1111", {busy_rf, busy_wf, busy_nc, busy_l2});
    end
    checks++;
    if ({val_rf, val_wf, val_nc, val_l2} !== 4'h0 || dout_rf !== 32'h0 || dout_l2 !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_out valid=%b rf=%h l2=%h exp=0", {val_rf, val_wf, val_nc, val_l2}, dout_rf, dout_l2);
    end
    n = 0;
    while (busy_rf && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++; $display("[TB] FAIL clear_length got=%0d exp=16", n);
    end
    checks++;
    if ({busy_rf, busy_wf, busy_nc, busy_l2} !== 4'h0) begin
      failures++; $display("[TB] FAIL clear_done got=%b exp=0000", {busy_rf, busy_wf, busy_nc, busy_l2});
    end
  endtask

  task automatic test_clear_reads();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), v1, drf, dwf, dnc, v2, d2);
      checks++;
      if (v1 !== 3'b111 || drf !== 32'h0 || dwf !== 32'h0 || dnc !== 32'h0) begin
        failures++; $display("[TB] FAIL clear_read_l1 addr=%0d valid=%b rf=%h wf=%h nc=%h exp=111/0", a, v1, drf, dwf, dnc);
      end
      checks++;
      if (v2 !== 1'b1 || d2 !== 32'h0) begin
        failures++; $display("[TB] FAIL clear_read_l2 addr=%0d valid=%b data=%h exp=1/0", a, v2, d2);
      end
    end
  endtask

  task automatic test_full_write();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    do_write(4'd3, 2'b11, 64'hAAAA_BBBB_1111_2222);
    do_read(5'd6, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h1111_2222 || dwf !== 32'h1111_2222 || dnc !== 32'h1111_2222 || v2 !== 1'b1 || d2 !== 32'h1111_2222) begin
      failures++; $display("[TB] FAIL full_write_lo valid=%b/%b rf=%h wf=%h nc=%h l2=%h exp=11112222", v1, v2, drf, dwf, dnc, d2);
    end
    do_read(5'd7, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'hAAAA_BBBB || dwf !== 32'hAAAA_BBBB || dnc !== 32'hAAAA_BBBB || v2 !== 1'b1 || d2 !== 32'hAAAA_BBBB) begin
      failures++; $display("[TB] FAIL full_write_hi valid=%b/%b rf=%h wf=%h nc=%h l2=%h exp=aaaabbbb", v1, v2, drf, dwf, dnc, d2);
    end
  endtask

  task automatic test_partial_write();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    do_write(4'd3, 2'b10, 64'hDEAD_BEEF_0000_0000);
    do_read(5'd6, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h1111_2222 || dnc !== 32'h1111_2222 || d2 !== 32'h1111_2222) begin
      failures++; $display("[TB] FAIL partial_lo_kept valid=%b rf=%h nc=%h l2=%h exp=11112222", v1, drf, dnc, d2);
    end
    do_read(5'd7, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'hDEAD_BEEF || dwf !== 32'hDEAD_BEEF || d2 !== 32'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL partial_hi valid=%b rf=%h wf=%h l2=%h exp=deadbeef", v1, drf, dwf, d2);
    end
  endtask

  task automatic test_collision();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    do_read(5'd6, v1, drf, dwf, dnc, v2, d2);
    addra = 4'd3; wea = 2'b10; dina = 64'h5555_5555_0000_0000; ena = 1'b1;
    addrb = 5'd7; enb = 1'b1;
    tick();
    ena = 1'b0; enb = 1'b0; wea = 2'b00;
    checks++;
    if (val_rf !== 1'b1 || dout_rf !== 32'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL coll_read_first valid=%b data=%h exp=1/deadbeef", val_rf, dout_rf);
    end
    checks++;
    if (val_wf !== 1'b1 || dout_wf !== 32'h5555_5555) begin
      failures++; $display("[TB] FAIL coll_write_first valid=%b data=%h exp=1/55555555", val_wf, dout_wf);
    end
    checks++;
    if (val_nc !== 1'b0 || dout_nc !== 32'h1111_2222) begin
      failures++; $display("[TB] FAIL coll_no_change valid=%b data=%h exp=0/11112222", val_nc, dout_nc);
    end
    tick();
    checks++;
    if (val_l2 !== 1'b1 || dout_l2 !== 32'hDEAD_BEEF || val_nc !== 1'b0 || dout_nc !== 32'h1111_2222) begin
      failures++; $display("[TB] FAIL coll_lat2 l2=%b/%h nc=%b/%h exp=1/deadbeef 0/11112222", val_l2, dout_l2, val_nc, dout_nc);
    end
    do_read(5'd7, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h5555_5555 || dwf !== 32'h5555_5555 || dnc !== 32'h5555_5555 || d2 !== 32'h5555_5555) begin
      failures++; $display("[TB] FAIL coll_written valid=%b rf=%h wf=%h nc=%h l2=%h exp=55555555", v1, drf, dwf, dnc, d2);
    end
  endtask

  task automatic test_same_word_other_lane();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    addra = 4'd3; wea = 2'b01; dina = 64'hFFFF_FFFF_7777_7777; ena = 1'b1;
    addrb = 5'd7; enb = 1'b1;
    tick();
    ena = 1'b0; enb = 1'b0; wea = 2'b00;
    checks++;
    if ({val_rf, val_wf, val_nc} !== 3'b111 || dout_rf !== 32'h5555_5555 || dout_wf !== 32'h5555_5555 || dout_nc !== 32'h5555_5555) begin
      failures++; $display("[TB] FAIL other_lane valid=%b rf=%h wf=%h nc=%h exp=111/55555555", {val_rf, val_wf, val_nc}, dout_rf, dout_wf, dout_nc);
    end
    tick();
    do_read(5'd6, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h7777_7777 || dnc !== 32'h7777_7777 || d2 !== 32'h7777_7777) begin
      failures++; $display("[TB] FAIL other_lane_written valid=%b rf=%h nc=%h l2=%h exp=77777777", v1, drf, dnc, d2);
    end
  endtask

  task automatic test_back_to_back();
    addrb = 5'd6; enb = 1'b1;
    tick();
    checks++;
    if (val_rf !== 1'b1 || dout_rf !== 32'h7777_7777 || val_l2 !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_e1 rf=%b/%h l2v=%b exp=1/77777777 0", val_rf, dout_rf, val_l2);
    end
    addrb = 5'd7;
    tick();
    checks++;
    if (val_rf !== 1'b1 || dout_rf !== 32'h5555_5555 || val_l2 !== 1'b1 || dout_l2 !== 32'h7777_7777) begin
      failures++; $display("[TB] FAIL b2b_e2 rf=%b/%h l2=%b/%h exp=1/55555555 1/77777777", val_rf, dout_rf, val_l2, dout_l2);
    end
    addrb = 5'd6;
    tick();
    checks++;
    if (val_rf !== 1'b1 || dout_rf !== 32'h7777_7777 || val_l2 !== 1'b1 || dout_l2 !== 32'h5555_5555) begin
      failures++; $display("[TB] FAIL b2b_e3 rf=%b/%h l2=%b/%h exp=1/77777777 1/55555555", val_rf, dout_rf, val_l2, dout_l2);
    end
    enb = 1'b0; addrb = 5'd7;
    tick();
    checks++;
    if (val_rf !== 1'b0 || dout_rf !== 32'h7777_7777 || val_l2 !== 1'b1 || dout_l2 !== 32'h7777_7777) begin
      failures++; $display("[TB] FAIL b2b_e4 rf=%b/%h l2=%b/%h exp=0/77777777 1/77777777", val_rf, dout_rf, val_l2, dout_l2);
    end
    tick();
    checks++;
    if (val_l2 !== 1'b0 || dout_l2 !== 32'h7777_7777) begin
      failures++; $display("[TB] FAIL b2b_hold l2=%b/%h exp=0/77777777", val_l2, dout_l2);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] v1; logic [31:0] drf, dwf, dnc, d2; logic v2;
    int n;
    int leaks;
    addrb = 5'd7; enb = 1'b1;
    tick();
    enb = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({val_rf, val_wf, val_nc, val_l2} !== 4'h0 || dout_rf !== 32'h0 || dout_l2 !== 32'h0 || busy_l2 !== 1'b1) begin
      failures++; $display("[TB] FAIL inflight_reset valid=%b rf=%h l2=%h busy=%b exp=0000/0/0/1", {val_rf, val_wf, val_nc, val_l2}, dout_rf, dout_l2, busy_l2);
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addra = 4'd0; wea = 2'b11; dina = 64'hFFFF_FFFF_FFFF_FFFF; ena = 1'b1;
    addrb = 5'd0; enb = 1'b1;
    n = 0;
    leaks = 0;
    while (busy_rf && n < 64) begin
      tick();
      n++;
      if ({val_rf, val_wf, val_nc, val_l2} !== 4'h0) leaks++;
    end
    ena = 1'b0; enb = 1'b0; wea = 2'b00;
    checks++;
    if (n != 16) begin
      failures++; $display("[TB] FAIL mid_clear_length got=%0d exp=16", n);
    end
    checks++;
    if (leaks != 0) begin
      failures++; $display("[TB] FAIL busy_valid_leak got=%0d exp=0", leaks);
    end
    do_read(5'd0, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h0 || dnc !== 32'h0 || d2 !== 32'h0) begin
      failures++; $display("[TB] FAIL busy_write_ignored_lo valid=%b rf=%h nc=%h l2=%h exp=0", v1, drf, dnc, d2);
    end
    do_read(5'd1, v1, drf, dwf, dnc, v2, d2);
    checks++;
    if (v1 !== 3'b111 || drf !== 32'h0 || dwf !== 32'h0 || d2 !== 32'h0) begin
      failures++; $display("[TB] FAIL busy_write_ignored_hi valid=%b rf=%h wf=%h l2=%h exp=0", v1, drf, dwf, d2);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; ena = 1'b0; wea = 2'b00; addra = 4'd0; dina = 64'h0;
    enb = 1'b0; addrb = 5'd0;
    @(negedge clk);
    test_reset();
    test_clear_reads();
    test_full_write();
    test_partial_write();
    test_collision();
    test_same_word_other_lane();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
